// File: rtl/rf_writeback_ctrl.sv
// Register file write-back controller: buffered ALU results, priority loads, busy scoreboard.
// Optional decode forwarding port enabled by defining RF_WB_BYPASS_EN.
module rf_writeback_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_dst,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   ld_valid,
    input  logic [ADDR_W-1:0]      ld_dst,
    input  logic [DATA_W-1:0]      ld_data,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_dst,
    output logic [(1<<ADDR_W)-1:0] busy_mask,
    output logic [ADDR_W-1:0]      DstReg,
    output logic                   WriteReg,
    output logic [DATA_W-1:0]      DstData
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]      byp_reg,
    output logic                   byp_hit,
    output logic [DATA_W-1:0]      byp_data
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] r_fifo_dst  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_push;
    logic              w_pop;
    logic              w_sel_valid;
    logic [ADDR_W-1:0] w_sel_dst;
    logic [DATA_W-1:0] w_sel_data;
    logic [NREG-1:0]   w_clr;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_busy_next;

    // Ready comes from the registered count only, so a full FIFO never accepts.
    assign alu_ready   = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push      = alu_valid & alu_ready;
    assign w_pop       = ~ld_valid & (r_count != '0);
    assign w_sel_valid = ld_valid | w_pop;
    assign w_sel_dst   = ld_valid ? ld_dst  : r_fifo_dst[r_rd_ptr];
    assign w_sel_data  = ld_valid ? ld_data : r_fifo_data[r_rd_ptr];

    // A new issue to the register being retired keeps its busy bit.
    assign w_clr       = WriteReg  ? (NREG'(1) << DstReg)  : '0;
    assign w_set       = iss_valid ? (NREG'(1) << iss_dst) : '0;
    assign w_busy_next = ((busy_mask & ~w_clr) | w_set) & ~NREG'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_dst[i]  <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            busy_mask <= '0;
            DstReg    <= '0;
            WriteReg  <= 1'b0;
            DstData   <= '0;
        end else begin
            if (w_push) begin
                r_fifo_dst[r_wr_ptr]  <= alu_dst;
                r_fifo_data[r_wr_ptr] <= alu_data;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            busy_mask <= w_busy_next;
            // R0 results are consumed but never written.
            WriteReg  <= w_sel_valid & (w_sel_dst != '0);
            if (w_sel_valid) begin
                DstReg  <= w_sel_dst;
                DstData <= w_sel_data;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign byp_hit  = WriteReg & (DstReg == byp_reg) & (byp_reg != '0);
    assign byp_data = byp_hit ? DstData : '0;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: directed scenarios then random traffic
// against a queue-based reference model.
module tb_rf_writeback_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_dst;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [3:0]  ld_dst;
    logic [15:0] ld_data;
    logic        iss_valid;
    logic [3:0]  iss_dst;
    logic [15:0] busy_mask;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
`ifdef RF_WB_BYPASS_EN
    logic [3:0]  byp_reg;
    logic        byp_hit;
    logic [15:0] byp_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0]  q_dst [$];
    logic [15:0] q_data [$];
    logic        m_wr;
    logic [3:0]  m_dst;
    logic [15:0] m_data;
    logic [15:0] m_busy;

    always #5 clk = ~clk;

    rf_writeback_ctrl dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_dst(iss_dst),
        .busy_mask(busy_mask), .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData)
`ifdef RF_WB_BYPASS_EN
        , .byp_reg(byp_reg), .byp_hit(byp_hit), .byp_data(byp_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_dst = 0; alu_data = 0;
        ld_valid  = 0; ld_dst  = 0; ld_data  = 0;
        iss_valid = 0; iss_dst = 0;
    endtask

    task automatic model_clear();
        q_dst.delete(); q_data.delete();
        m_wr = 0; m_dst = 0; m_data = 0; m_busy = 0;
    endtask

    // Check outputs against the model, then advance model and DUT one clock.
    task automatic step();
        logic        accept;
        logic [15:0] nb;
        chk("alu_ready", alu_ready, q_dst.size() < 4);
        chk("busy_mask", busy_mask, m_busy);
        chk("WriteReg", WriteReg, m_wr);
        chk("DstReg", DstReg, m_dst);
        chk("DstData", DstData, m_data);
`ifdef RF_WB_BYPASS_EN
        byp_reg = ($urandom_range(1) == 1) ? m_dst : 4'($urandom);
        #1;
        chk("byp_hit", byp_hit, m_wr && (m_dst == byp_reg) && (byp_reg != 0));
        chk("byp_data", byp_data, (m_wr && (m_dst == byp_reg) && (byp_reg != 0)) ? m_data : 16'h0);
`endif
        accept = alu_valid && (q_dst.size() < 4);
        nb = m_busy;
        if (m_wr) nb[m_dst] = 1'b0;
        if (iss_valid) nb[iss_dst] = 1'b1;
        nb[0] = 1'b0;
        m_busy = nb;
        if (ld_valid) begin
            m_wr = (ld_dst != 0); m_dst = ld_dst; m_data = ld_data;
        end else if (q_dst.size() > 0) begin
            m_dst = q_dst.pop_front(); m_data = q_data.pop_front(); m_wr = (m_dst != 0);
        end else begin
            m_wr = 0;
        end
        if (accept) begin
            q_dst.push_back(alu_dst); q_data.push_back(alu_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        #2;
        model_clear();
        chk("rst_WriteReg", WriteReg, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_DstReg", DstReg, 0);
        chk("rst_DstData", DstData, 0);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
`ifdef RF_WB_BYPASS_EN
        byp_reg = 0;
`endif
        #3;
        do_reset();

        // ALU push R3 appears two edges later
        alu_valid = 1; alu_dst = 3; alu_data = 16'h1234;
        step();
        idle_inputs();
        step();
        chk("t1_WriteReg", WriteReg, 1);
        chk("t1_DstReg", DstReg, 3);
        chk("t1_DstData", DstData, 16'h1234);
        step();

        // load beats queued R2
        alu_valid = 1; alu_dst = 2; alu_data = 16'h0001;
        ld_valid = 1; ld_dst = 5; ld_data = 16'hBEEF;
        step();
        alu_valid = 0;
        step();
        idle_inputs();
        chk("t2_DstReg_ld", DstReg, 5);
        step();
        chk("t2_DstReg_alu", DstReg, 2);
        step();

        // fill FIFO under load pressure, then drain
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1; alu_dst = 4'(8 + i); alu_data = 16'(16'hA000 + i);
            ld_valid = 1; ld_dst = 4'(1 + i); ld_data = 16'(16'h5000 + i);
            step();
        end
        chk("t3_full", alu_ready, 0);
        idle_inputs();
        for (int i = 0; i < 6; i++) step();

        // R0 destination
        alu_valid = 1; alu_dst = 0; alu_data = 16'hFFFF; iss_valid = 1; iss_dst = 0;
        step();
        idle_inputs();
        step();
        chk("t4_WriteReg", WriteReg, 0);
        chk("t4_busy", busy_mask, 0);
        step();

        // scoreboard set/clear races
        iss_valid = 1; iss_dst = 7; step();
        iss_valid = 0; ld_valid = 1; ld_dst = 7; ld_data = 16'h0077; step();
        ld_valid = 0; iss_valid = 1; iss_dst = 7; step();
        iss_valid = 0;
        chk("t5_busy7", busy_mask[7], 1);
        iss_valid = 1; iss_dst = 4; step();
        iss_valid = 0; ld_valid = 1; ld_dst = 4; ld_data = 16'h0044; step();
        ld_valid = 0; step();
        chk("t5_busy4", busy_mask[4], 0);
        step();

`ifdef RF_WB_BYPASS_EN
        ld_valid = 1; ld_dst = 9; ld_data = 16'h00AA; step();
        ld_valid = 0;
        byp_reg = 9; #1;
        chk("t6_hit", byp_hit, 1);
        chk("t6_data", byp_data, 16'h00AA);
        byp_reg = 0; #1;
        chk("t6_hit_r0", byp_hit, 0);
        step();
`endif

        // reset with entries queued
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_dst = 4'(3 + i); alu_data = 16'(i + 1);
            ld_valid = 1; ld_dst = 1; ld_data = 16'h0101;
            iss_valid = 1; iss_dst = 4'(10 + i);
            step();
        end
        do_reset();
        for (int i = 0; i < 4; i++) step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            alu_valid = ($urandom_range(99) < 60);
            alu_dst   = 4'($urandom);
            alu_data  = 16'($urandom);
            ld_valid  = ($urandom_range(99) < 30);
            ld_dst    = 4'($urandom);
            ld_data   = 16'($urandom);
            iss_valid = ($urandom_range(99) < 50);
            iss_dst   = 4'($urandom);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
